// File: rtl/cv32e40x_pkg.sv
// Shared definitions for the AMO adapter: AMO funct5 encodings, FSM state
// enum and the internal transaction-kind enum.
package cv32e40x_pkg;

    // RISC-V A-extension funct5 encodings (instruction bits 31:27)
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } amo_fsm_e;

    // Kind of the transaction currently in flight
    typedef enum logic [2:0] {
        OP_READ,
        OP_WRITE,
        OP_LR,
        OP_SC,
        OP_RMW
    } amo_op_e;

    // True for the read-modify-write AMOs handled by the ALU
    function automatic logic is_rmw(input logic [4:0] funct5);
        case (funct5)
            AMO_SWAP, AMO_ADD, AMO_XOR, AMO_AND, AMO_OR,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: is_rmw = 1'b1;
            default:                              is_rmw = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cv32e40x_amo_alu.sv
// Combinational AMO ALU: computes the value written back by a
// read-modify-write AMO from the old memory word and the core operand.
module cv32e40x_amo_alu
    import cv32e40x_pkg::*;
(
    input  logic [4:0]  funct5,
    input  logic [31:0] old,
    input  logic [31:0] operand,
    output logic [31:0] result
);

    // Select the write-back value; SWAP (and anything unlisted) writes the operand
    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = operand;
        case (funct5)
            AMO_ADD:  result = old + operand;
            AMO_XOR:  result = old ^ operand;
            AMO_AND:  result = old & operand;
            AMO_OR:   result = old | operand;
            AMO_MIN:  result = ($signed(old) < $signed(operand)) ? old : operand;
            AMO_MAX:  result = ($signed(old) > $signed(operand)) ? old : operand;
            AMO_MINU: result = (old < operand) ? old : operand;
            AMO_MAXU: result = (old > operand) ? old : operand;
            default:  result = operand;
        endcase
    end

endmodule

// File: rtl/cv32e40x_amo_adapter.sv
// Converts core-side atomic accesses (LR/SC/AMO) into plain memory reads and
// writes. One transaction is in flight at a time; LR/SC use a single
// word-granular reservation register.
module cv32e40x_amo_adapter
    import cv32e40x_pkg::*;
#(
    parameter int RESV_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        s_req_i,
    output logic        s_gnt_o,
    input  logic [31:0] s_addr_i,
    input  logic        s_we_i,
    input  logic [3:0]  s_be_i,
    input  logic [31:0] s_wdata_i,
    input  logic [5:0]  s_atop_i,
    output logic        s_rvalid_o,
    output logic [31:0] s_rdata_o,
    output logic        s_err_o,

    output logic        m_req_o,
    output logic [31:0] m_addr_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i,
    input  logic        m_err_i
);

    localparam logic RESV_ON = (RESV_ENABLE != 0);

    amo_fsm_e    state_q;
    amo_op_e     op_q;
    logic [4:0]  funct5_q;
    logic [31:0] operand_q;
    logic [31:0] old_q;
    logic        resv_valid_q;
    logic [29:0] resv_addr_q;

    logic [31:0] alu_result;
    logic [31:0] word_addr;
    logic        sc_hit;
    logic        wr_hits_resv;

    assign word_addr    = {s_addr_i[31:2], 2'b00};
    assign sc_hit       = RESV_ON && resv_valid_q && (resv_addr_q == s_addr_i[31:2]);
    assign wr_hits_resv = resv_valid_q && (resv_addr_q == m_addr_o[31:2]);

    // Grant only while idle; gated by rst_n so no grant is seen during reset
    assign s_gnt_o = rst_n && (state_q == IDLE) && s_req_i;

    cv32e40x_amo_alu u_alu (
        .funct5  (funct5_q),
        .old     (m_rdata_i),
        .operand (operand_q),
        .result  (alu_result)
    );

    // Transaction FSM with registered memory-side and core-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset too, so every output reads 0 while in reset.
            state_q      <= IDLE;
            op_q         <= OP_READ;
            funct5_q     <= 5'd0;
            operand_q    <= 32'd0;
            old_q        <= 32'd0;
            resv_valid_q <= 1'b0;
            resv_addr_q  <= 30'd0;
            m_req_o      <= 1'b0;
            m_addr_o     <= 32'd0;
            m_we_o       <= 1'b0;
            m_be_o       <= 4'd0;
            m_wdata_o    <= 32'd0;
            s_rvalid_o   <= 1'b0;
            s_rdata_o    <= 32'd0;
            s_err_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            case (state_q)
                IDLE: begin
                    if (s_req_i) begin
                        funct5_q  <= s_atop_i[4:0];
                        operand_q <= s_wdata_i;
                        m_wdata_o <= s_wdata_i;
                        if (!s_atop_i[5]) begin
                            // Plain access passes through unchanged
                            m_addr_o <= s_addr_i;
                            m_be_o   <= s_be_i;
                            m_we_o   <= s_we_i;
                            m_req_o  <= 1'b1;
                            op_q     <= s_we_i ? OP_WRITE : OP_READ;
                            state_q  <= s_we_i ? WR_REQ : RD_REQ;
                        end else begin
                            m_addr_o <= word_addr;
                            m_be_o   <= 4'hF;
                            case (s_atop_i[4:0])
                                AMO_LR: begin
                                    op_q    <= OP_LR;
                                    m_we_o  <= 1'b0;
                                    m_req_o <= 1'b1;
                                    state_q <= RD_REQ;
                                end
                                AMO_SC: begin
                                    // Any SC consumes the reservation
                                    resv_valid_q <= 1'b0;
                                    op_q         <= OP_SC;
                                    if (sc_hit) begin
                                        m_we_o  <= 1'b1;
                                        m_req_o <= 1'b1;
                                        state_q <= WR_REQ;
                                    end else begin
                                        s_rvalid_o <= 1'b1;
                                        s_rdata_o  <= 32'd1;
                                        s_err_o    <= 1'b0;
                                        state_q    <= RESP;
                                    end
                                end
                                default: begin
                                    if (is_rmw(s_atop_i[4:0])) begin
                                        op_q    <= OP_RMW;
                                        m_we_o  <= 1'b0;
                                        m_req_o <= 1'b1;
                                        state_q <= RD_REQ;
                                    end else begin
                                        // Unsupported atomic: reject without touching memory
                                        s_rvalid_o <= 1'b1;
                                        s_rdata_o  <= 32'd0;
                                        s_err_o    <= 1'b1;
                                        state_q    <= RESP;
                                    end
                                end
                            endcase
                        end
                    end
                end

                RD_REQ: begin
                    if (m_gnt_i) begin
                        m_req_o <= 1'b0;
                        state_q <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (m_rvalid_i) begin
                        if (op_q == OP_RMW && !m_err_i) begin
                            // Read succeeded: write back the ALU result
                            old_q     <= m_rdata_i;
                            m_wdata_o <= alu_result;
                            m_we_o    <= 1'b1;
                            m_req_o   <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            if (op_q == OP_LR && !m_err_i && RESV_ON) begin
                                resv_valid_q <= 1'b1;
                                resv_addr_q  <= m_addr_o[31:2];
                            end
                            s_rvalid_o <= 1'b1;
                            s_rdata_o  <= m_rdata_i;
                            s_err_o    <= m_err_i;
                            state_q    <= RESP;
                        end
                    end
                end

                WR_REQ: begin
                    if (m_gnt_i) begin
                        m_req_o <= 1'b0;
                        state_q <= WR_WAIT;
                        // A granted store to the reserved word breaks the reservation
                        if (wr_hits_resv) begin
                            resv_valid_q <= 1'b0;
                        end
                    end
                end

                WR_WAIT: begin
                    if (m_rvalid_i) begin
                        s_rvalid_o <= 1'b1;
                        s_rdata_o  <= (op_q == OP_RMW) ? old_q : 32'd0;
                        s_err_o    <= m_err_i;
                        state_q    <= RESP;
                    end
                end

                RESP: begin
                    s_rvalid_o <= 1'b0;
                    s_rdata_o  <= 32'd0;
                    s_err_o    <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40x_amo_adapter.sv
// Self-checking bench for cv32e40x_amo_adapter: directed transactions, a
// memory model on the memory side and a scoreboard checking core responses.
module tb_cv32e40x_amo_adapter;

    localparam logic [5:0] A_LR   = 6'b1_00010;
    localparam logic [5:0] A_SC   = 6'b1_00011;
    localparam logic [5:0] A_SWAP = 6'b1_00001;
    localparam logic [5:0] A_ADD  = 6'b1_00000;
    localparam logic [5:0] A_XOR  = 6'b1_00100;
    localparam logic [5:0] A_AND  = 6'b1_01100;
    localparam logic [5:0] A_OR   = 6'b1_01000;
    localparam logic [5:0] A_MIN  = 6'b1_10000;
    localparam logic [5:0] A_MAX  = 6'b1_10100;
    localparam logic [5:0] A_MINU = 6'b1_11000;
    localparam logic [5:0] A_MAXU = 6'b1_11100;
    localparam logic [5:0] A_BAD  = 6'b1_00101;
    localparam logic [5:0] PLAIN  = 6'b0_00000;

    logic        clk;
    logic        rst_n;
    logic        s_req_i;
    logic        s_gnt_o;
    logic [31:0] s_addr_i;
    logic        s_we_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_wdata_i;
    logic [5:0]  s_atop_i;
    logic        s_rvalid_o;
    logic [31:0] s_rdata_o;
    logic        s_err_o;
    logic        m_req_o;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic [31:0] m_rdata_i;
    logic        m_err_i;

    cv32e40x_amo_adapter #(.RESV_ENABLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_req_i    (s_req_i),
        .s_gnt_o    (s_gnt_o),
        .s_addr_i   (s_addr_i),
        .s_we_i     (s_we_i),
        .s_be_i     (s_be_i),
        .s_wdata_i  (s_wdata_i),
        .s_atop_i   (s_atop_i),
        .s_rvalid_o (s_rvalid_o),
        .s_rdata_o  (s_rdata_o),
        .s_err_o    (s_err_o),
        .m_req_o    (m_req_o),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_wdata_o  (m_wdata_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .m_err_i    (m_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [int unsigned];
    int  stall        = 0;
    bit  err_on_read  = 0;
    bit  err_on_write = 0;
    int  req_cnt      = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] addr);
        int unsigned k = int'(addr >> 2);
        return mem.exists(k) ? mem[k] : 32'd0;
    endfunction

    task automatic check_mem(input string name, input logic [31:0] addr, input logic [31:0] exp);
        check(name, mem_rd(addr), exp);
    endtask

    assign m_gnt_i = m_req_o && (stall == 0);

    initial begin : slave
        bit          g;
        bit          held_valid;
        logic [31:0] a, wd, h_addr, h_wdata;
        logic        we;
        logic [3:0]  be;
        logic [31:0] cur;
        held_valid = 0;
        m_rvalid_i = 0;
        m_rdata_i  = 0;
        m_err_i    = 0;
        forever begin
            @(negedge clk);
            if (m_req_o && stall != 0) begin
                // Request fields must hold still while the grant is withheld
                if (held_valid) begin
                    check("req_stable_addr", m_addr_o, h_addr);
                    check("req_stable_wdata", m_wdata_o, h_wdata);
                end
                h_addr = m_addr_o;
                h_wdata = m_wdata_o;
                held_valid = 1;
                stall--;
            end else begin
                held_valid = 0;
            end
            #1;
            g  = m_req_o && m_gnt_i;
            a  = m_addr_o;
            we = m_we_o;
            be = m_be_o;
            wd = m_wdata_o;
            @(posedge clk);
            #1;
            m_rvalid_i = g;
            m_rdata_i  = 32'd0;
            m_err_i    = 1'b0;
            if (g) begin
                req_cnt++;
                if (!we) begin
                    m_rdata_i = mem_rd(a);
                    m_err_i   = err_on_read;
                end else begin
                    cur = mem_rd(a);
                    for (int i = 0; i < 4; i++)
                        if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
                    mem[int'(a >> 2)] = cur;
                    m_err_i = err_on_write;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_rvalid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", {31'b0, s_rvalid_o}, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_rdata"}, s_rdata_o, e.rdata);
                    check({e.name, "_err"}, {31'b0, s_err_o}, {31'b0, e.err});
                    if (e.lat > 0) check({e.name, "_latency"}, 32'(cyc - e.gcyc), 32'(e.lat));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [5:0] atop, output bit ok,
                         output int gcyc);
        ok = 0;
        @(negedge clk);
        s_req_i   = 1'b1;
        s_addr_i  = addr;
        s_we_i    = we;
        s_be_i    = be;
        s_wdata_i = wdata;
        s_atop_i  = atop;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (s_gnt_o) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        gcyc = cyc;
        @(posedge clk);
        #1;
        s_req_i = 1'b0;
    endtask

    task automatic do_req(input string name, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata, input logic [5:0] atop,
                          input logic [31:0] er, input logic ee, input int lat);
        bit   ok;
        int   gcyc;
        exp_t e;
        issue(addr, we, be, wdata, atop, ok, gcyc);
        if (!ok) begin
            check({name, "_grant_timeout"}, 32'd0, 32'd1);
            return;
        end
        e.name = name; e.rdata = er; e.err = ee; e.gcyc = gcyc; e.lat = lat;
        sb.push_back(e);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            check({name, "_resp_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int  rc;
        bit  ok;
        int  gcyc;
        bit  seen;

        rst_n = 1'b0;
        s_req_i = 1'b1; s_addr_i = 0; s_we_i = 0; s_be_i = 0; s_wdata_i = 0; s_atop_i = 0;
        mem[32'h100 >> 2] = 32'h5;
        mem[32'h104 >> 2] = 32'h0;
        mem[32'h200 >> 2] = 32'hFFFF_FFFF;
        mem[32'h208 >> 2] = 32'hFFFF_FFFF;
        mem[32'h210 >> 2] = 32'h0F0F_00FF;
        mem[32'h220 >> 2] = 32'h11;
        mem[32'h300 >> 2] = 32'hAB;
        mem[32'h400 >> 2] = 32'h0;

        // Reset state
        #12;
        check("rst_gnt", {31'b0, s_gnt_o}, 32'h0);
        check("rst_mreq", {31'b0, m_req_o}, 32'h0);
        check("rst_rvalid", {31'b0, s_rvalid_o}, 32'h0);
        s_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Plain accesses, including a partial byte-enable write
        do_req("wr_full", 32'h104, 1, 4'hF, 32'hA5A5_0000, PLAIN, 32'h0, 0, 3);
        check_mem("mem_wr_full", 32'h104, 32'hA5A5_0000);
        do_req("wr_half", 32'h104, 1, 4'h3, 32'h0000_1234, PLAIN, 32'h0, 0, 3);
        check_mem("mem_wr_half", 32'h104, 32'hA5A5_1234);
        do_req("rd_plain", 32'h104, 0, 4'hF, 32'h0, PLAIN, 32'hA5A5_1234, 0, 3);

        // LR then SC succeeds; a second SC fails without memory traffic
        do_req("lr_a", 32'h100, 0, 4'hF, 32'h0, A_LR, 32'h5, 0, 3);
        do_req("sc_pass", 32'h100, 0, 4'hF, 32'h9, A_SC, 32'h0, 0, 3);
        check_mem("mem_sc_pass", 32'h100, 32'h9);
        rc = req_cnt;
        do_req("sc_again", 32'h100, 0, 4'hF, 32'hE, A_SC, 32'h1, 0, 0);
        check("sc_again_noreq", 32'(req_cnt), 32'(rc));
        check_mem("mem_sc_again", 32'h100, 32'h9);

        // Intervening store to the reserved word kills the reservation
        do_req("lr_b", 32'h100, 0, 4'hF, 32'h0, A_LR, 32'h9, 0, 3);
        do_req("wr_resv", 32'h100, 1, 4'hF, 32'h77, PLAIN, 32'h0, 0, 3);
        rc = req_cnt;
        do_req("sc_broken", 32'h100, 0, 4'hF, 32'h55, A_SC, 32'h1, 0, 0);
        check("sc_broken_noreq", 32'(req_cnt), 32'(rc));
        check_mem("mem_sc_broken", 32'h100, 32'h77);

        // Store to another word keeps the reservation
        do_req("lr_c", 32'h100, 0, 4'hF, 32'h0, A_LR, 32'h77, 0, 3);
        do_req("wr_other", 32'h104, 1, 4'hF, 32'h0, PLAIN, 32'h0, 0, 3);
        do_req("sc_keep", 32'h100, 0, 4'hF, 32'h66, A_SC, 32'h0, 0, 3);
        check_mem("mem_sc_keep", 32'h100, 32'h66);

        // Signed vs unsigned max
        do_req("amomax", 32'h200, 0, 4'hF, 32'h1, A_MAX, 32'hFFFF_FFFF, 0, 5);
        check_mem("mem_amomax", 32'h200, 32'h1);
        mem[32'h200 >> 2] = 32'hFFFF_FFFF;
        do_req("amomaxu", 32'h200, 0, 4'hF, 32'h1, A_MAXU, 32'hFFFF_FFFF, 0, 5);
        check_mem("mem_amomaxu", 32'h200, 32'hFFFF_FFFF);

        // Modulo add
        do_req("amoadd", 32'h208, 0, 4'hF, 32'h2, A_ADD, 32'hFFFF_FFFF, 0, 5);
        check_mem("mem_amoadd", 32'h208, 32'h1);

        // Logic ops and min, chained on one word
        do_req("amoxor", 32'h210, 0, 4'hF, 32'hFF00_FF00, A_XOR, 32'h0F0F_00FF, 0, 5);
        check_mem("mem_amoxor", 32'h210, 32'hF00F_FFFF);
        do_req("amoand", 32'h210, 0, 4'hF, 32'h00FF_00F0, A_AND, 32'hF00F_FFFF, 0, 5);
        check_mem("mem_amoand", 32'h210, 32'h000F_00F0);
        do_req("amoor", 32'h210, 0, 4'hF, 32'h8000_0001, A_OR, 32'h000F_00F0, 0, 5);
        check_mem("mem_amoor", 32'h210, 32'h800F_00F1);
        do_req("amomin", 32'h210, 0, 4'hF, 32'h5, A_MIN, 32'h800F_00F1, 0, 5);
        check_mem("mem_amomin", 32'h210, 32'h800F_00F1);
        do_req("amominu", 32'h210, 0, 4'hF, 32'h5, A_MINU, 32'h800F_00F1, 0, 5);
        check_mem("mem_amominu", 32'h210, 32'h5);
        // Unaligned address and narrow byte enables must become a full-word access
        do_req("amoswap", 32'h213, 0, 4'h1, 32'hCAFE_BABE, A_SWAP, 32'h5, 0, 5);
        check_mem("mem_amoswap", 32'h210, 32'hCAFE_BABE);

        // RMW read error: no write issued
        err_on_read = 1;
        rc = req_cnt;
        do_req("swap_rderr", 32'h220, 0, 4'hF, 32'h99, A_SWAP, 32'h11, 1, 0);
        err_on_read = 0;
        check("swap_rderr_reqs", 32'(req_cnt), 32'(rc + 1));
        check_mem("mem_swap_rderr", 32'h220, 32'h11);

        // RMW write error: old value returned with err
        err_on_write = 1;
        do_req("add_wrerr", 32'h220, 0, 4'hF, 32'h1, A_ADD, 32'h11, 1, 5);
        err_on_write = 0;

        // Unsupported funct5
        rc = req_cnt;
        do_req("bad_amo", 32'h220, 0, 4'hF, 32'h1, A_BAD, 32'h0, 1, 0);
        check("bad_amo_noreq", 32'(req_cnt), 32'(rc));

        // Withheld grant: fields held stable
        stall = 3;
        do_req("rd_stall", 32'h104, 0, 4'hF, 32'h0, PLAIN, 32'h0, 0, 0);

        // Reset during WR_WAIT of an AMO, reservation must be lost
        do_req("lr_d", 32'h300, 0, 4'hF, 32'h0, A_LR, 32'hAB, 0, 3);
        issue(32'h400, 0, 4'hF, 32'h55, A_SWAP, ok, gcyc);
        check("rst_swap_grant", {31'b0, ok}, 32'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_req_o && m_we_o) begin
                seen = 1;
                break;
            end
        end
        check("rst_swap_wrreq_seen", {31'b0, seen}, 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        s_req_i = 1'b1;
        #1;
        check("rst_mid_mreq", {31'b0, m_req_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mid_rvalid", {31'b0, s_rvalid_o}, 32'h0);
            check("rst_mid_gnt", {31'b0, s_gnt_o}, 32'h0);
        end
        s_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rc = req_cnt;
        do_req("sc_after_rst", 32'h300, 0, 4'hF, 32'h1, A_SC, 32'h1, 0, 0);
        check("sc_after_rst_noreq", 32'(req_cnt), 32'(rc));
        check_mem("mem_sc_after_rst", 32'h300, 32'hAB);

        // Reset while a request is pending drops m_req_o at once
        stall = 1000;
        issue(32'h104, 0, 4'hF, 32'h0, PLAIN, ok, gcyc);
        @(negedge clk);
        check("pend_mreq_high", {31'b0, m_req_o}, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("pend_mreq_drop", {31'b0, m_req_o}, 32'h0);
        @(negedge clk);
        stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req("rd_recover", 32'h104, 0, 4'hF, 32'h0, PLAIN, 32'h0, 0, 3);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
